// File: rtl/memory_responder_pkg.sv
// Shared address map, bus-direction encodings and state type for the 6502 memory responder.
package memory_responder_pkg;

    localparam logic [15:0] RAM_MIRROR_END = 16'h1FFF;
    localparam logic [15:0] ROM_BASE       = 16'hF000;
    localparam logic        RW_READ        = 1'b1;
    localparam logic        RW_WRITE       = 1'b0;
    localparam int          RAM_DEPTH      = 2048;
    localparam int          ROM_DEPTH      = 4096;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_ROM,
        REGION_NONE
    } region_t;

    function automatic region_t decode(input logic [15:0] address);
        if (address <= RAM_MIRROR_END) begin
            return REGION_RAM;
        end else if (address >= ROM_BASE) begin
            return REGION_ROM;
        end
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/memory_array.sv
// Generic storage array: asynchronous read port, synchronous write port.
module memory_array #(
    parameter int  DEPTH     = 2048,
    parameter int  WIDTH     = 8,
    parameter bit  INIT_ZERO = 1'b0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [WIDTH-1:0] FILL = INIT_ZERO ? {WIDTH{1'b0}} : {WIDTH{1'bx}};

    logic [WIDTH-1:0] mem [DEPTH] = '{default: FILL};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_responder.sv
// 6502 bus responder: mirrored zero-wait RAM, wait-stated ROM with host preload, open-bus unmapped space.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int WAIT_STATES   = 2,
    parameter bit ROM_INIT_ZERO = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_address,
    input  logic        i_rw,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        o_rdy,
    input  logic        i_load,
    input  logic [11:0] i_load_address,
    input  logic [7:0]  i_load_data,
    output logic        o_rom_write_err
);

    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [2:0] WAIT_LOAD = NO_WAIT ? 3'd0 : 3'(WAIT_STATES - 1);

    state_t      state;
    logic [2:0]  count;
    logic [15:0] wait_address;
    logic [7:0]  open_bus;
    logic        snap_valid;
    logic [15:0] snap_address;
    logic [7:0]  snap_data;

    logic [7:0]  ram_rdata;
    logic [7:0]  rom_rdata;
    logic [7:0]  rom_byte;
    logic [7:0]  rd_data;
    region_t     region;
    logic        is_ram;
    logic        is_rom;
    logic        is_write;
    logic        in_wait;
    logic        rom_done;
    logic        rdy;
    logic        enter_wait;
    logic        snap_hit;
    logic        snap_capture;
    logic        ram_we;

    assign region   = decode(i_address);
    assign is_ram   = (region == REGION_RAM);
    assign is_rom   = (region == REGION_ROM);
    assign is_write = (i_rw == RW_WRITE);

    // A stall only continues while the CPU keeps presenting the very address that started it.
    assign in_wait    = (state == ST_WAIT) && (i_address == wait_address);
    assign rom_done   = NO_WAIT || (in_wait && (count == 3'd0));
    assign rdy        = (!is_rom || rom_done) && !i_load;
    assign enter_wait = !i_load && is_rom && !NO_WAIT && !in_wait;
    assign ram_we     = rdy && is_ram && is_write;

    // The ROM byte is snapshotted when a stalled access begins so a preload landing mid-access
    // cannot change what that access returns.
    assign snap_hit     = snap_valid && (snap_address == i_address);
    assign snap_capture = is_rom && !rdy && !snap_hit;
    assign rom_byte     = snap_hit ? snap_data : rom_rdata;

    always_comb begin
        rd_data = open_bus;
        if (is_ram) begin
            rd_data = ram_rdata;
        end else if (is_rom) begin
            rd_data = rom_byte;
        end
    end

    assign o_data = rd_data;
    assign o_rdy  = rdy;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            count           <= 3'd0;
            open_bus        <= 8'h00;
            o_rom_write_err <= 1'b0;
            snap_valid      <= 1'b0;
        end else begin
            if (!i_load) begin
                if (enter_wait) begin
                    state <= ST_WAIT;
                    count <= WAIT_LOAD;
                end else if (in_wait && (count != 3'd0)) begin
                    count <= count - 3'd1;
                end else begin
                    state <= ST_IDLE;
                    count <= 3'd0;
                end
            end
            if (rdy && is_rom && is_write) begin
                o_rom_write_err <= 1'b1;
            end
            if (rdy) begin
                if (is_write) begin
                    open_bus <= i_data;
                end else if (region != REGION_NONE) begin
                    open_bus <= rd_data;
                end
            end
            if (rdy || !is_rom) begin
                snap_valid <= 1'b0;
            end else if (snap_capture) begin
                snap_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (enter_wait) begin
            wait_address <= i_address;
        end
        if (snap_capture) begin
            snap_address <= i_address;
            snap_data    <= rom_rdata;
        end
    end

    memory_array #(
        .DEPTH    (RAM_DEPTH),
        .WIDTH    (8),
        .INIT_ZERO(1'b0)
    ) u_ram (
        .clk  (i_clk),
        .we   (ram_we),
        .waddr(i_address[10:0]),
        .wdata(i_data),
        .raddr(i_address[10:0]),
        .rdata(ram_rdata)
    );

    memory_array #(
        .DEPTH    (ROM_DEPTH),
        .WIDTH    (8),
        .INIT_ZERO(ROM_INIT_ZERO)
    ) u_rom (
        .clk  (i_clk),
        .we   (i_load),
        .waddr(i_load_address),
        .wdata(i_load_data),
        .raddr(i_address[11:0]),
        .rdata(rom_rdata)
    );

endmodule

// File: tb/tb_memory_responder.sv
// Randomized and directed bench for memory_responder against a transaction-level memory model.
module tb_memory_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        rw;
    logic [7:0]  wdata;
    logic        load;
    logic [11:0] load_address;
    logic [7:0]  load_data;
    logic [7:0]  data, data_z;
    logic        rdy, rdy_z;
    logic        err, err_z;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram_m [2048];
    logic [7:0] rom_m [4096];
    logic [7:0] ob_m;
    logic       err_m;

    always #5 clk = ~clk;

    memory_responder #(.WAIT_STATES(W), .ROM_INIT_ZERO(1'b0)) dut (
        .i_clk(clk), .i_reset(reset), .i_address(address), .i_rw(rw), .i_data(wdata),
        .o_data(data), .o_rdy(rdy), .i_load(load), .i_load_address(load_address),
        .i_load_data(load_data), .o_rom_write_err(err)
    );

    memory_responder #(.WAIT_STATES(0), .ROM_INIT_ZERO(1'b1)) dut_z (
        .i_clk(clk), .i_reset(reset), .i_address(address), .i_rw(rw), .i_data(wdata),
        .o_data(data_z), .o_rdy(rdy_z), .i_load(load), .i_load_address(load_address),
        .i_load_data(load_data), .o_rom_write_err(err_z)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 = RAM, 1 = ROM, 2 = unmapped
    function automatic int region_of(input logic [15:0] a);
        if (a < 16'h2000) return 0;
        if (a >= 16'hF000) return 1;
        return 2;
    endfunction

    // One complete CPU access: ROM takes W stall cycles, everything else completes at once.
    task automatic access(input logic [15:0] a, input logic rd, input logic [7:0] d);
        int         rg;
        int         stalls;
        logic [7:0] exp;
        rg     = region_of(a);
        stalls = (rg == 1) ? W : 0;
        exp    = (rg == 0) ? ram_m[a[10:0]] : (rg == 1) ? rom_m[a[11:0]] : ob_m;
        address = a;
        rw      = rd;
        wdata   = d;
        for (int k = 0; k <= stalls; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("err", err, err_m);
                check("err_z", err_z, err_m);
                check("rdy_z", rdy_z, 1'b1);
                if (rd) check("data_z", data_z, exp);
            end
            check("rdy", rdy, k == stalls);
            if (k == stalls && rd) check("data", data, exp);
            @(posedge clk);
            #1;
        end
        if (rd) begin
            ob_m = exp;
        end else begin
            ob_m = d;
            if (rg == 0) ram_m[a[10:0]] = d;
            if (rg == 1) err_m = 1'b1;
        end
    endtask

    task automatic load_rom(input logic [11:0] idx, input logic [7:0] val);
        address      = 16'h4000;
        rw           = 1'b1;
        load         = 1'b1;
        load_address = idx;
        load_data    = val;
        @(negedge clk);
        check("rdy_load", rdy, 1'b0);
        @(posedge clk);
        #1;
        load       = 1'b0;
        rom_m[idx] = val;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] old;
        logic [7:0] nv;
        reset = 1'b1; address = 16'h4000; rw = 1'b1; wdata = 8'h00;
        load = 1'b0; load_address = 12'h000; load_data = 8'h00;
        ob_m = 8'h00; err_m = 1'b0;

        #12;
        check("reset_err", err, 1'b0);
        check("reset_ob", data, 8'h00);
        check("reset_rdy", rdy, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Zero-wait instance completes ROM at once and starts cleared; the W instance stalls.
        address = 16'hF123; rw = 1'b1;
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("w0_rdy", rdy_z, 1'b1);
                check("w0_zero", data_z, 8'h00);
            end
            check("w_rdy", rdy, k == W);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 4096; i++) load_rom(12'(i), 8'($urandom));
        for (int i = 0; i < 2048; i++) access(16'(i), 1'b0, 8'($urandom));

        // Mirroring
        access(16'h0005, 1'b0, 8'h5A);
        access(16'h0805, 1'b1, 8'h00);
        // Reset vector
        load_rom(12'hFFC, 8'h00);
        load_rom(12'hFFD, 8'hF0);
        access(16'hFFFC, 1'b1, 8'h00);
        access(16'hFFFD, 1'b1, 8'h00);
        // ROM write protection
        load_rom(12'h010, 8'h11);
        access(16'hF010, 1'b0, 8'h77);
        access(16'hF010, 1'b1, 8'h00);
        // Open bus
        access(16'h0005, 1'b1, 8'h00);
        access(16'h4000, 1'b1, 8'h00);

        // Reset during the first stall cycle
        address = 16'hFFFC; rw = 1'b1;
        @(negedge clk);
        check("rst_wait_rdy", rdy, 1'b0);
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1 check("rst_mid_err", err, 1'b0);
        address = 16'h4000;
        #1 check("rst_mid_ob", data, 8'h00);
        address = 16'hFFFC;
        @(posedge clk); #1;
        reset = 1'b0; err_m = 1'b0; ob_m = 8'h00;
        access(16'hFFFC, 1'b1, 8'h00);
        access(16'h0005, 1'b1, 8'h00);

        // Preload colliding with a RAM write: first pass abandons the write, second holds it.
        for (int pass = 0; pass < 2; pass++) begin
            address = 16'h0010; rw = 1'b0; wdata = 8'h33;
            load = 1'b1; load_address = 12'h123; load_data = 8'($urandom);
            @(negedge clk);
            check("coll_rdy", rdy, 1'b0);
            @(posedge clk); #1;
            load = 1'b0;
            rom_m[12'h123] = load_data;
            if (pass == 0) access(16'h0010, 1'b1, 8'h00);
            else access(16'h0010, 1'b0, 8'h33);
        end
        access(16'h0010, 1'b1, 8'h00);

        // Preload colliding with a ROM read of the same byte
        old = rom_m[12'h200];
        nv  = ~old;
        address = 16'hF200; rw = 1'b1;
        load = 1'b1; load_address = 12'h200; load_data = nv;
        @(negedge clk);
        check("rcoll_rdy", rdy, 1'b0);
        check("rcoll_rdy_z", rdy_z, 1'b0);
        @(posedge clk); #1;
        load = 1'b0;
        access(16'hF200, 1'b1, 8'h00);
        rom_m[12'h200] = nv;
        access(16'hF200, 1'b1, 8'h00);

        // Address leaves ROM mid-stall
        address = 16'hF010; rw = 1'b1;
        @(negedge clk);
        check("chg_rdy", rdy, 1'b0);
        @(posedge clk); #1;
        access(16'h0005, 1'b1, 8'h00);
        access(16'hF010, 1'b1, 8'h00);

        for (int i = 0; i < 400; i++) begin
            int sel;
            logic [15:0] a;
            sel = int'($urandom_range(0, 3));
            if (sel == 0) begin
                load_rom(12'($urandom), 8'($urandom));
            end else begin
                if (sel == 1) a = 16'($urandom_range(0, 16'h1FFF));
                else if (sel == 2) a = 16'hF000 | 16'($urandom_range(0, 16'h0FFF));
                else a = 16'($urandom_range(16'h2000, 16'hEFFF));
                access(a, 1'($urandom_range(0, 1)), 8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, sets the number of stall cycles for every ROM access (0..7).
REQ-002 Parameter ROM_INIT_ZERO, default 0, clears ROM at elaboration when 1; when 0, ROM contents are X.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  reset; asynchronous, active-high.
REQ-005 i_address  input  16  CPU address bus (ABH:ABL).
REQ-006 i_rw  input  1  CPU bus direction; 1 = read, 0 = write.
REQ-007 i_data  input  8  CPU write data.
REQ-008 o_data  output  8  read data to the CPU data latch.
REQ-009 o_rdy  output  1  high when the current access completes this cycle (6502 RDY).
REQ-010 i_load  input  1  host ROM preload strobe.
REQ-011 i_load_address  input  12  ROM offset for the preload.
REQ-012 i_load_data  input  8  ROM preload byte.
REQ-013 o_rom_write_err  output  1  sticky flag: the CPU attempted a write to ROM.

Function
REQ-014 Address decoding SHALL be as follows:
- RAM: 0x0000-0x1FFF, 2 KiB, index = address[10:0], mirrored four times.
- ROM: 0xF000-0xFFFF, 4 KiB, index = address[11:0].
- Unmapped: all other addresses.
REQ-015 State machine SHALL have two states:
- IDLE.
- WAIT, with a 3-bit counter.
REQ-016 RAM accesses SHALL complete in the cycle they are presented, with o_rdy=1 combinationally.
REQ-017 A RAM read SHALL drive o_data combinationally from the RAM array.
REQ-018 A RAM write SHALL commit i_data at the rising edge that ends a cycle with o_rdy=1 and i_rw=0.
REQ-019 ROM access with WAIT_STATES=W>0, in IDLE:
- o_rdy=0 combinationally.
- Next state is WAIT with the counter loaded to W-1.
REQ-020 ROM access in WAIT:
- o_rdy=0 while the counter is nonzero; the counter decrements each edge.
- When the counter is 0: o_rdy=1, o_data = ROM byte, next state IDLE.
REQ-021 With WAIT_STATES=0, a ROM access SHALL complete like RAM: o_rdy=1 in the first cycle.
REQ-022 If i_address leaves the ROM region or changes value while in WAIT, the responder SHALL return to IDLE and evaluate the new address as a fresh access.
REQ-023 A CPU write to ROM SHALL leave ROM unchanged and set o_rom_write_err at the completing edge; it is cleared only by reset.
REQ-024 Unmapped accesses:
- o_rdy=1.
- Writes are ignored.
- Reads return the open-bus register.
REQ-025 The open-bus register SHALL capture o_data at every edge that completes a mapped read, and i_data at every edge that completes any write.
REQ-026 When i_load=1:
- ROM[i_load_address] is written at the edge.
- o_rdy is forced to 0 that cycle.
- The state and counter hold.
- No CPU write commits.
REQ-027 Simultaneous i_load and a CPU ROM read of the same index SHALL return the old byte after the stall resolves.

Reset
REQ-028 While i_reset=1, the state SHALL be IDLE, the counter 0, the open-bus register 8'h00, and o_rom_write_err=0, independent of i_clk.
REQ-029 Reset SHALL NOT clear RAM or ROM contents.
REQ-030 Reset asserted mid-WAIT SHALL abandon the access; after release, the access restarts with the full W stall.

Structure
REQ-031 A shared package SHALL hold:
- RAM_MIRROR_END=16'h1FFF.
- ROM_BASE=16'hF000.
- RW_READ=1 and RW_WRITE=0.
- The state enumeration.
REQ-032 A single sub-module, memory_array (parameterised depth/width, async read, sync write), SHALL be instantiated once for RAM and once for ROM.

Verification
REQ-033 Mirroring: write 0x5A to 0x0005, then read 0x0805 -> o_rdy=1 in both cycles and o_data=0x5A.
REQ-034 Reset vector with W=2: preload 0xFFC=0x00 and 0xFFD=0xF0, then read 0xFFFC -> o_rdy sequence 0,0,1 and o_data=0x00 on the third cycle; read 0xFFFD -> o_data=0xF0 on its third cycle.
REQ-035 ROM write protection: write 0x77 to 0xF010 (ROM byte preloaded 0x11) -> o_rdy low for 2 cycles then high; o_rom_write_err=1 after the completing edge; a subsequent read returns 0x11.
REQ-036 Open bus: read 0x0005 (0x5A), then read 0x4000 -> o_data=0x5A with o_rdy=1.
REQ-037 Reset mid-WAIT: assert i_reset during the first stall cycle of a read of 0xFFFC -> o_rom_write_err=0 and open bus 0x00; after release the read stalls 2 cycles again; RAM[0x005] still reads 0x5A.
REQ-038 Load collision: i_load=1 in the same cycle as a CPU write of 0x33 to 0x0010 -> o_rdy=0 and RAM unchanged that cycle; the write commits on the following cycle.
